set_time: RTL and testbench
===========================

Name: set_time

Overview:
- Time-setting controller for a 24-hour HH:MM digital clock.
- After `start`, the user edits four BCD digits one at a time (h1, h0, min1, min0). Each `up` press increments the selected digit with wrap; each `nextDigit` press moves the cursor on.
- Outputs feed the display and the timekeeping core's preset path.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on each of start/nextDigit/up (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state.
- start  input  1  button level; its rising edge enters edit mode at digit h1.
- nextDigit  input  1  button level; its rising edge advances the cursor.
- up  input  1  button level; its rising edge increments the selected digit.
- h1  output  4  BCD tens-of-hours, 0..2.
- h0  output  4  BCD units-of-hours, 0..9; 0..3 when h1==2.
- min1  output  4  BCD tens-of-minutes, 0..5.
- min0  output  4  BCD units-of-minutes, 0..9.
- editing  output  1  high while in edit mode.
- digit_sel  output  2  cursor position: 0=h1, 1=h0, 2=min1, 3=min0; 0 when idle.

Behaviour:
- Reset (reset==0, asynchronous):
  - h1=h0=min1=min0=0, editing=0, digit_sel=0.
  - State IDLE; synchronizer and edge-detect flops cleared to 0.
- Input conditioning:
  - Each button passes through SYNC_STAGES flops, then a one-flop rising-edge detector producing a 1-cycle pulse.
  - Action latency: the resulting update is visible after the (SYNC_STAGES+1)th rising clk edge following the input rise.
  - A held level produces exactly one pulse. Falling edges do nothing.
- States: IDLE, SET_H1, SET_H0, SET_M1, SET_M0.
- Transitions:
  - start pulse (any state) -> SET_H1; digit values are kept.
  - nextDigit pulse: SET_H1->SET_H0->SET_M1->SET_M0->IDLE. Ignored in IDLE.
- Priority for pulses in the same cycle: start > nextDigit > up. The lower-priority pulse is dropped that cycle.
- up pulse, by state (ignored in IDLE):
  - SET_H1: h1 = (h1==2) ? 0 : h1+1. If the new h1 is 2 and h0>3, h0 is forced to 0 in the same cycle.
  - SET_H0: limit = (h1==2) ? 3 : 9; h0 = (h0==limit) ? 0 : h0+1.
  - SET_M1: min1 = (min1==5) ? 0 : min1+1.
  - SET_M0: min0 = (min0==9) ? 0 : min0+1.
- Output encoding:
  - editing = (state != IDLE).
  - digit_sel = 0/1/2/3 for SET_H1/SET_H0/SET_M1/SET_M0; 0 in IDLE.
- Outputs are registered. Digits never leave their legal BCD range, so the outputs always form a valid 00:00–23:59 time.
- Reset asserted mid-edit: immediate return to all-zero IDLE. Pulses whose edges were in flight in the synchronizer are discarded.
- After returning to IDLE, digit values hold indefinitely until the next start or reset.

Test Plan:
- Reset then idle: hold reset=0 for 5 cycles, release, pulse up 3 times -> all digits 0, editing=0 throughout.
- h1 wrap: start pulse, then 10 up pulses -> h1 steps 1,2,0,1,2,0,1,2,0,1; final h1=1, digit_sel=0, editing=1.
- h0 limit: from h1=1, nextDigit, 8 up pulses -> h0=8. Then start, one up (h1=2) -> h0 forced to 0. Then nextDigit, 5 ups -> h0 sequence 1,2,3,0,1.
- Minutes: nextDigit to min1, 17 ups -> min1=5 (17 mod 6). nextDigit to min0, 5 ups -> min0=5. nextDigit -> editing=0, digit_sel=0, time held.
- Edge/priority: hold up high for 20 cycles -> exactly one increment. Assert up and nextDigit in the same cycle -> cursor advances, no increment.
- Async reset mid-edit: at SET_M1 with time 21:37, drive reset low between clock edges -> outputs read 00:00 and editing=0 before the next clk edge.

Source files
------------

// File: rtl/set_time.sv
// Time-setting controller for a 24-hour HH:MM clock.
// Debounced-by-sync button edges drive a digit cursor and BCD increments.
module set_time #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       nextDigit,
  input  logic       up,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic       editing,
  output logic [1:0] digit_sel
);

  typedef enum logic [2:0] {
    IDLE,
    SET_H1,
    SET_H0,
    SET_M1,
    SET_M0
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] s_start;
  logic [SYNC_STAGES-1:0] s_next;
  logic [SYNC_STAGES-1:0] s_up;
  logic                   d_start;
  logic                   d_next;
  logic                   d_up;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_start <= '0;
      s_next  <= '0;
      s_up    <= '0;
      d_start <= 1'b0;
      d_next  <= 1'b0;
      d_up    <= 1'b0;
    end else begin
      s_start <= {s_start[SYNC_STAGES-2:0], start};
      s_next  <= {s_next[SYNC_STAGES-2:0], nextDigit};
      s_up    <= {s_up[SYNC_STAGES-2:0], up};
      d_start <= s_start[SYNC_STAGES-1];
      d_next  <= s_next[SYNC_STAGES-1];
      d_up    <= s_up[SYNC_STAGES-1];
    end
  end

  logic p_start;
  logic p_next;
  logic p_up;

  assign p_start = s_start[SYNC_STAGES-1] & ~d_start;
  assign p_next  = s_next[SYNC_STAGES-1] & ~d_next;
  assign p_up    = s_up[SYNC_STAGES-1] & ~d_up;

  logic [3:0] h1_inc;

  assign h1_inc = (h1 == 4'd2) ? 4'd0 : h1 + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      h1        <= 4'd0;
      h0        <= 4'd0;
      min1      <= 4'd0;
      min0      <= 4'd0;
      editing   <= 1'b0;
      digit_sel <= 2'd0;
    end else if (p_start) begin
      state     <= SET_H1;
      editing   <= 1'b1;
      digit_sel <= 2'd0;
    end else if (p_next) begin
      case (state)
        SET_H1: begin
          state     <= SET_H0;
          digit_sel <= 2'd1;
        end
        SET_H0: begin
          state     <= SET_M1;
          digit_sel <= 2'd2;
        end
        SET_M1: begin
          state     <= SET_M0;
          digit_sel <= 2'd3;
        end
        SET_M0: begin
          state     <= IDLE;
          editing   <= 1'b0;
          digit_sel <= 2'd0;
        end
        default: ;
      endcase
    end else if (p_up) begin
      case (state)
        SET_H1: begin
          h1 <= h1_inc;
          // Entering the 20s must not leave an illegal 24..29 hour.
          if (h1_inc == 4'd2 && h0 > 4'd3)
            h0 <= 4'd0;
        end
        SET_H0: begin
          if (h0 == ((h1 == 4'd2) ? 4'd3 : 4'd9))
            h0 <= 4'd0;
          else
            h0 <= h0 + 4'd1;
        end
        SET_M1: min1 <= (min1 == 4'd5) ? 4'd0 : min1 + 4'd1;
        SET_M0: min0 <= (min0 == 4'd9) ? 4'd0 : min0 + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_time.sv
// Bench for set_time: directed plan plus random presses
// checked against a digit-level time model.
module tb_set_time;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       nextDigit = 1'b0;
  logic       up = 1'b0;
  logic [3:0] h1;
  logic [3:0] h0;
  logic [3:0] min1;
  logic [3:0] min0;
  logic       editing;
  logic [1:0] digit_sel;

  int checks = 0;
  int failures = 0;

  int  mh1 = 0;
  int  mh0 = 0;
  int  mm1 = 0;
  int  mm0 = 0;
  int  cur = 0;
  bit  med = 1'b0;

  set_time #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .nextDigit(nextDigit),
    .up(up),
    .h1(h1),
    .h0(h0),
    .min1(min1),
    .min0(min0),
    .editing(editing),
    .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mh1 = 0; mh0 = 0; mm1 = 0; mm0 = 0;
    cur = 0; med = 1'b0;
  endtask

  task automatic act(input bit s, input bit n, input bit u);
    if (s) begin
      med = 1'b1;
      cur = 0;
    end else if (n && med) begin
      if (cur == 3) begin
        med = 1'b0;
        cur = 0;
      end else begin
        cur = cur + 1;
      end
    end else if (u && med) begin
      case (cur)
        0: begin
          mh1 = (mh1 + 1) % 3;
          if (mh1 == 2 && mh0 > 3) mh0 = 0;
        end
        1: mh0 = (mh0 + 1) % ((mh1 == 2) ? 4 : 10);
        2: mm1 = (mm1 + 1) % 6;
        default: mm0 = (mm0 + 1) % 10;
      endcase
    end
  endtask

  task automatic chk(input string tag);
    logic [17:0] got;
    logic [17:0] exp;
    got = {h1, h0, min1, min0, editing, digit_sel};
    exp = {mh1[3:0], mh0[3:0], mm1[3:0], mm0[3:0], med, cur[1:0]};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h%h:%h%h ed=%b sel=%0d exp=%0d%0d:%0d%0d ed=%b sel=%0d",
             tag, h1, h0, min1, min0, editing, digit_sel,
             mh1, mh0, mm1, mm0, med, cur);
    end
  endtask

  task automatic press(input bit s, input bit n, input bit u,
                       input int hold);
    @(negedge clk);
    start = s; nextDigit = n; up = u;
    repeat (SYNC) @(posedge clk);
    #1 chk("latency");
    @(posedge clk);
    act(s, n, u);
    #1 chk("action");
    for (int i = SYNC + 1; i < hold; i++) begin
      @(posedge clk);
      #1 chk("held");
    end
    @(negedge clk);
    start = 1'b0; nextDigit = 1'b0; up = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1 chk("release");
  endtask

  task automatic ups(input int k);
    for (int i = 0; i < k; i++) press(1'b0, 1'b0, 1'b1, 4);
  endtask

  initial begin
    // Reset and idle
    repeat (5) @(posedge clk);
    #1 chk("in_reset");
    @(negedge clk) reset = 1'b1;
    ups(3);
    chk("idle_ignores_up");

    // h1 wrap
    press(1'b1, 1'b0, 1'b0, 4);
    ups(10);
    chk("h1_wrap");

    // h0 limit and forced clear
    press(1'b0, 1'b1, 1'b0, 4);
    ups(8);
    chk("h0_eight");
    press(1'b1, 1'b0, 1'b0, 4);
    ups(1);
    chk("h0_forced");
    press(1'b0, 1'b1, 1'b0, 4);
    ups(5);
    chk("h0_limit3");

    // Minutes and exit
    press(1'b0, 1'b1, 1'b0, 4);
    ups(17);
    press(1'b0, 1'b1, 1'b0, 4);
    ups(5);
    press(1'b0, 1'b1, 1'b0, 4);
    chk("exit_hold");
    repeat (20) @(posedge clk);
    #1 chk("idle_hold");

    // Held level and priority
    press(1'b1, 1'b0, 1'b0, 4);
    press(1'b0, 1'b0, 1'b1, 20);
    press(1'b0, 1'b1, 1'b1, 4);
    press(1'b1, 1'b1, 1'b1, 5);
    press(1'b0, 1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 1'b1, 4);
    chk("prio_idle");

    // Random presses
    for (int i = 0; i < 80; i++) begin
      bit s, n, u;
      int r;
      r = $urandom_range(0, 15);
      s = (r == 0);
      n = (r >= 1 && r <= 4) || (r == 15);
      u = (r >= 5);
      press(s, n, u, $urandom_range(3, 7));
    end

    // Build 21:37 parked at min1
    press(1'b1, 1'b0, 1'b0, 4);
    while (mh1 != 2) ups(1);
    press(1'b0, 1'b1, 1'b0, 4);
    while (mh0 != 1) ups(1);
    press(1'b0, 1'b1, 1'b0, 4);
    while (mm1 != 3) ups(1);
    press(1'b0, 1'b1, 1'b0, 4);
    while (mm0 != 7) ups(1);
    press(1'b1, 1'b0, 1'b0, 4);
    press(1'b0, 1'b1, 1'b0, 4);
    press(1'b0, 1'b1, 1'b0, 4);
    chk("at_2137");

    // Async reset with an up edge in flight
    @(negedge clk) up = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 chk("async_reset");
    @(negedge clk) reset = 1'b1;
    up = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
